// File: rtl/i2c_arb_sched_if.sv
// i2c_arb_sched_if -- bundle of every non-clock signal of i2c_arb_sched.
//
// Signal groups:
//   requester side : req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 (to arbiter),
//                    done0/done1, err, rdata, grant (from arbiter)
//   I2C master side: m_start, m_we, m_dev_addr, m_reg_addr, m_wdata (from arbiter),
//                    m_done, m_nack, m_rdata (to arbiter)
//
// Modports:
//   slave  : the arbiter's view (i2c_arb_sched itself)
//   master : the environment's view (requesters plus byte-level master)
interface i2c_arb_sched_if;
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       done0;
    logic       done1;
    logic       err;
    logic [7:0] rdata;
    logic [1:0] grant;
    logic       m_start;
    logic       m_we;
    logic [6:0] m_dev_addr;
    logic [7:0] m_reg_addr;
    logic [7:0] m_wdata;
    logic       m_done;
    logic       m_nack;
    logic [7:0] m_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  m_done, m_nack, m_rdata,
        output done0, done1, err, rdata, grant,
        output m_start, m_we, m_dev_addr, m_reg_addr, m_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output m_done, m_nack, m_rdata,
        input  done0, done1, err, rdata, grant,
        input  m_start, m_we, m_dev_addr, m_reg_addr, m_wdata
    );
endinterface

// File: rtl/i2c_arb_sched.sv
// i2c_arb_sched -- two-requester round-robin scheduler in front of a
// byte-level I2C master talking to an EEPROM.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous reset, active-low
//   bus    : i2c_arb_sched_if.slave (requester commands/status and the
//            command/response handshake with the byte-level master)
//
// Flow: IDLE picks an owner and latches its command, ISSUE pulses m_start,
// WAIT waits for m_done (bounded by TIMEOUT_CYC), GAP holds the bus for
// WR_GAP_CYC cycles after a successful write so the EEPROM can finish its
// internal write cycle.
module i2c_arb_sched #(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter logic [23:0] WR_GAP_CYC  = 24'd4800,
    parameter logic [23:0] TIMEOUT_CYC = 24'd100000
) (
    input  logic           clk,
    input  logic           rst_n,
    i2c_arb_sched_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        owner_q, owner_d;      // current/last owner: 0 = requester 0, 1 = requester 1
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        start_q, start_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        err_q, err_d;
    logic [23:0] cnt_q, cnt_d;

    logic        any_req;
    logic        pick1;
    logic [23:0] cnt_inc;
    logic        timeout_hit;
    logic        gap_last;
    logic        wr_ok;

    assign any_req = bus.req0 | bus.req1;
    // Requester 1 wins when it is alone, or on a tie when requester 0 owned last.
    assign pick1   = bus.req1 & (~bus.req0 | ~owner_q);
    assign cnt_inc = (cnt_q == 24'hFF_FFFF) ? cnt_q : cnt_q + 24'd1;
    // Compare count+1 against the limit in 25 bits so a limit of 0 never
    // underflows into "wait forever".
    assign timeout_hit = ({1'b0, cnt_q} + 25'd1) >= {1'b0, TIMEOUT_CYC};
    assign gap_last    = ({1'b0, cnt_q} + 25'd1) >= {1'b0, WR_GAP_CYC};
    assign wr_ok       = we_q & ~bus.m_nack;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.m_done) begin
                    state_d = wr_ok ? S_GAP : S_IDLE;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_GAP:   if (gap_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        grant_d = grant_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        start_d = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_d = pick1;
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    we_d    = pick1 ? bus.we1    : bus.we0;
                    addr_d  = pick1 ? bus.addr1  : bus.addr0;
                    wdata_d = pick1 ? bus.wdata1 : bus.wdata0;
                end
            end
            S_ISSUE: begin
                start_d = 1'b1;
                cnt_d   = 24'd0;
            end
            S_WAIT: begin
                if (bus.m_done) begin
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    err_d   = bus.m_nack;
                    if (!we_q && !bus.m_nack) rdata_d = bus.m_rdata;
                    if (!wr_ok) grant_d = 2'b00;
                    cnt_d   = 24'd0;
                end else if (timeout_hit) begin
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    err_d   = 1'b1;
                    grant_d = 2'b00;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_GAP: begin
                if (gap_last) grant_d = 2'b00;
                else          cnt_d   = cnt_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= 2'b00;
            owner_q <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            cnt_q   <= 24'd0;
        end else begin
            grant_q <= grant_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            start_q <= start_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done0      = done0_q;
    assign bus.done1      = done1_q;
    assign bus.err        = err_q;
    assign bus.rdata      = rdata_q;
    assign bus.m_start    = start_q;
    assign bus.m_we       = we_q;
    assign bus.m_dev_addr = DEV_ADDR;
    assign bus.m_reg_addr = addr_q;
    assign bus.m_wdata    = wdata_q;
endmodule

// File: tb/tb_i2c_arb_sched.sv
// Bench for i2c_arb_sched: directed scenarios followed by randomized
// transactions, checked against a rule-level model (round-robin owner,
// last read data, expected pulse counts).
module tb_i2c_arb_sched;
    localparam int GAP  = 4800;
    localparam int TOUT = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    i2c_arb_sched_if bus_if();

    i2c_arb_sched #(
        .DEV_ADDR   (7'h50),
        .WR_GAP_CYC (24'd4800),
        .TIMEOUT_CYC(24'd100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // pulse monitors (count high cycles at the falling edge)
    int dn0_cnt = 0;
    int dn1_cnt = 0;
    int st_cnt  = 0;
    always @(negedge clk) begin
        if (bus_if.done0 === 1'b1)   dn0_cnt++;
        if (bus_if.done1 === 1'b1)   dn1_cnt++;
        if (bus_if.m_start === 1'b1) st_cnt++;
    end

    // reference model state
    int         m_last = 1;
    logic [7:0] m_rd_exp = 8'h00;
    int         e_dn0 = 0;
    int         e_dn1 = 0;
    int         e_st  = 0;

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) return (m_last == 0) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_grant",  32'(bus_if.grant), 32'(0));
        chk("rst_mstart", 32'(bus_if.m_start), 32'(0));
        chk("rst_done0",  32'(bus_if.done0), 32'(0));
        chk("rst_done1",  32'(bus_if.done1), 32'(0));
        chk("rst_err",    32'(bus_if.err), 32'(0));
        chk("rst_rdata",  32'(bus_if.rdata), 32'(0));
        chk("rst_maddr",  32'(bus_if.m_reg_addr), 32'(0));
        chk("rst_mwdata", 32'(bus_if.m_wdata), 32'(0));
        chk("rst_mwe",    32'(bus_if.m_we), 32'(0));
        chk("rst_devadr", 32'(bus_if.m_dev_addr), 32'h50);
    endtask

    task automatic set_cmd(input int who, input bit we, input logic [7:0] a, input logic [7:0] d);
        if (who == 0) begin
            bus_if.we0 = we; bus_if.addr0 = a; bus_if.wdata0 = d;
        end else begin
            bus_if.we1 = we; bus_if.addr1 = a; bus_if.wdata1 = d;
        end
    endtask

    // Called from the IDLE state: expects m_start two edges later.
    task automatic start_phase(input int who, input bit we, input logic [7:0] a, input logic [7:0] d);
        int lat;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus_if.m_start !== 1'b1 && lat < 20);
        chk("start_latency", 32'(lat), 32'(2));
        chk("grant",       32'(bus_if.grant), (who == 1) ? 32'h2 : 32'h1);
        chk("m_we",        32'(bus_if.m_we), 32'(we));
        chk("m_reg_addr",  32'(bus_if.m_reg_addr), 32'(a));
        chk("m_wdata",     32'(bus_if.m_wdata), 32'(d));
        chk("m_dev_addr",  32'(bus_if.m_dev_addr), 32'h50);
        chk("done0_count", 32'(dn0_cnt), 32'(e_dn0));
        chk("done1_count", 32'(dn1_cnt), 32'(e_dn1));
        chk("start_count", 32'(st_cnt), 32'(e_st));
        e_st++;
        m_last = who;
        tick();
        chk("m_start_width", 32'(bus_if.m_start), 32'(0));
    endtask

    task automatic finish_phase(input int who, input bit we, input logic [7:0] a, input logic [7:0] d,
                                input bit nack, input logic [7:0] rd, input int lat);
        int k;
        repeat (lat) tick();
        bus_if.m_done  = 1'b1;
        bus_if.m_nack  = nack;
        bus_if.m_rdata = rd;
        tick();
        bus_if.m_done  = 1'b0;
        bus_if.m_nack  = 1'b0;
        bus_if.m_rdata = 8'($urandom);
        if (who == 0) e_dn0++; else e_dn1++;
        if (!we && !nack) m_rd_exp = rd;
        chk("done_owner", (who == 1) ? 32'(bus_if.done1) : 32'(bus_if.done0), 32'(1));
        chk("done_other", (who == 1) ? 32'(bus_if.done0) : 32'(bus_if.done1), 32'(0));
        chk("err",        32'(bus_if.err), 32'(nack));
        chk("rdata",      32'(bus_if.rdata), 32'(m_rd_exp));
        chk("hold_we",    32'(bus_if.m_we), 32'(we));
        chk("hold_addr",  32'(bus_if.m_reg_addr), 32'(a));
        chk("hold_wdata", 32'(bus_if.m_wdata), 32'(d));
        if (we && !nack) begin
            chk("gap_grant", 32'(bus_if.grant), (who == 1) ? 32'h2 : 32'h1);
            k = 0;
            while (bus_if.grant !== 2'b00 && k < GAP + 20) begin
                tick();
                k++;
            end
            chk("gap_length", 32'(k), 32'(GAP));
        end else begin
            chk("grant_release", 32'(bus_if.grant), 32'(0));
        end
    endtask

    initial begin
        int w, k;
        bit r0, r1, nack;
        bit we_w;
        logic [7:0] a_w, d_w;

        bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
        bus_if.we0 = 1'b0; bus_if.we1 = 1'b0;
        bus_if.addr0 = 8'h00; bus_if.addr1 = 8'h00;
        bus_if.wdata0 = 8'h00; bus_if.wdata1 = 8'h00;
        bus_if.m_done = 1'b0; bus_if.m_nack = 1'b0; bus_if.m_rdata = 8'h00;

        // reset state
        tick();
        tick();
        chk_reset_vals();
        #2 rst_n = 1'b1;
        tick();

        // both requesters raised together after reset, held: 0,1,0
        set_cmd(0, 1'b0, 8'h10, 8'h00);
        set_cmd(1, 1'b0, 8'h20, 8'h00);
        bus_if.req0 = 1'b1; bus_if.req1 = 1'b1;
        w = pick(1, 1);
        start_phase(w, 1'b0, (w == 1) ? 8'h20 : 8'h10, 8'h00);
        finish_phase(w, 1'b0, (w == 1) ? 8'h20 : 8'h10, 8'h00, 1'b0, 8'h3C, 3);
        w = pick(1, 1);
        start_phase(w, 1'b0, (w == 1) ? 8'h20 : 8'h10, 8'h00);
        finish_phase(w, 1'b0, (w == 1) ? 8'h20 : 8'h10, 8'h00, 1'b0, 8'hC3, 2);
        w = pick(1, 1);
        start_phase(w, 1'b0, (w == 1) ? 8'h20 : 8'h10, 8'h00);
        bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
        finish_phase(w, 1'b0, (w == 1) ? 8'h20 : 8'h10, 8'h00, 1'b0, 8'h5A, 1);
        tick();
        tick();
        chk("idle_grant",  32'(bus_if.grant), 32'(0));
        chk("idle_mstart", 32'(bus_if.m_start), 32'(0));

        // requester 0 write 05/A5, response after 50 cycles, then write gap;
        // requester 1 raises a read during WAIT/GAP and must wait it out
        set_cmd(0, 1'b1, 8'h05, 8'hA5);
        bus_if.req0 = 1'b1;
        start_phase(pick(1, 0), 1'b1, 8'h05, 8'hA5);
        bus_if.req0 = 1'b0;
        set_cmd(1, 1'b0, 8'h05, 8'h00);
        bus_if.req1 = 1'b1;
        finish_phase(0, 1'b1, 8'h05, 8'hA5, 1'b0, 8'h00, 49);

        // requester 1 read of 05 returns A5, no gap
        start_phase(pick(0, 1), 1'b0, 8'h05, 8'h00);
        bus_if.req1 = 1'b0;
        finish_phase(1, 1'b0, 8'h05, 8'h00, 1'b0, 8'hA5, 4);

        // NACKed write: no gap, next request follows at minimum latency
        set_cmd(0, 1'b1, 8'h33, 8'h44);
        bus_if.req0 = 1'b1;
        start_phase(pick(1, 0), 1'b1, 8'h33, 8'h44);
        bus_if.req0 = 1'b0;
        set_cmd(1, 1'b0, 8'h77, 8'h00);
        bus_if.req1 = 1'b1;
        finish_phase(0, 1'b1, 8'h33, 8'h44, 1'b1, 8'h00, 3);
        start_phase(pick(0, 1), 1'b0, 8'h77, 8'h00);
        bus_if.req1 = 1'b0;
        finish_phase(1, 1'b0, 8'h77, 8'h00, 1'b1, 8'h99, 2);

        // timeout: m_done never arrives, done 100 cycles after m_start
        set_cmd(1, 1'b0, 8'h12, 8'h00);
        bus_if.req1 = 1'b1;
        start_phase(pick(0, 1), 1'b0, 8'h12, 8'h00);
        bus_if.req1 = 1'b0;
        k = 1;
        while (bus_if.done1 !== 1'b1 && k < 2 * TOUT) begin
            tick();
            k++;
        end
        e_dn1++;
        chk("timeout_cycles", 32'(k), 32'(TOUT));
        chk("timeout_done0",  32'(bus_if.done0), 32'(0));
        chk("timeout_err",    32'(bus_if.err), 32'(1));
        chk("timeout_grant",  32'(bus_if.grant), 32'(0));
        bus_if.m_done = 1'b1; bus_if.m_nack = 1'b0; bus_if.m_rdata = 8'hEE;
        tick();
        bus_if.m_done = 1'b0;
        tick();
        chk("late_done1",  32'(bus_if.done1), 32'(0));
        chk("late_err",    32'(bus_if.err), 32'(1));
        chk("late_rdata",  32'(bus_if.rdata), 32'(m_rd_exp));
        chk("late_mstart", 32'(bus_if.m_start), 32'(0));

        // reset while in WAIT: immediate reset values, no done pulse
        set_cmd(0, 1'b0, 8'h66, 8'h00);
        bus_if.req0 = 1'b1;
        start_phase(pick(1, 0), 1'b0, 8'h66, 8'h00);
        bus_if.req0 = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        m_last = 1;
        m_rd_exp = 8'h00;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        bus_if.m_done = 1'b1; bus_if.m_rdata = 8'h11;
        tick();
        bus_if.m_done = 1'b0;
        chk("post_rst_done0", 32'(bus_if.done0), 32'(0));
        chk("post_rst_rdata", 32'(bus_if.rdata), 32'(0));
        set_cmd(0, 1'b0, 8'h67, 8'h00);
        bus_if.req0 = 1'b1;
        start_phase(pick(1, 0), 1'b0, 8'h67, 8'h00);
        bus_if.req0 = 1'b0;
        finish_phase(0, 1'b0, 8'h67, 8'h00, 1'b0, 8'h81, 2);

        // randomized traffic; in-flight command fields are scrambled
        for (int it = 0; it < 16; it++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            set_cmd(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            set_cmd(1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            bus_if.req0 = r0; bus_if.req1 = r1;
            w = pick(r0, r1);
            we_w = (w == 1) ? bus_if.we1 : bus_if.we0;
            a_w  = (w == 1) ? bus_if.addr1 : bus_if.addr0;
            d_w  = (w == 1) ? bus_if.wdata1 : bus_if.wdata0;
            start_phase(w, we_w, a_w, d_w);
            set_cmd(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            set_cmd(1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
            nack = ($urandom_range(0, 9) < 3);
            finish_phase(w, we_w, a_w, d_w, nack, 8'($urandom), $urandom_range(1, 8));
        end

        tick();
        tick();
        chk("final_done0_count", 32'(dn0_cnt), 32'(e_dn0));
        chk("final_done1_count", 32'(dn1_cnt), 32'(e_dn1));
        chk("final_start_count", 32'(st_cnt), 32'(e_st));
        chk("final_grant",       32'(bus_if.grant), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/i2c_arb_sched.md
I2C_ARB_SCHED -- requirements
Module: i2c_arb_sched

Interface
REQ-001 The block SHALL have a parameter DEV_ADDR, default 7'h50, the 7-bit I2C device address placed on m_dev_addr for every transaction.
REQ-002 The block SHALL have a parameter WR_GAP_CYC, default 24'd4800, the number of clk cycles to hold off after each successful write (EEPROM internal write time).
REQ-003 The block SHALL have a parameter TIMEOUT_CYC, default 24'd100000, the number of clk cycles to wait for m_done before aborting.
REQ-004 The block SHALL have these ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- req0 / req1  in  1  requester 0/1 transaction request (level)
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  8  EEPROM byte address
- wdata0 / wdata1  in  8  write data
- done0 / done1  out  1  one-cycle completion pulse to requester 0/1
- err  out  1  status of the last completed transaction: 1 = NACK or timeout
- rdata  out  8  read data of the last completed read
- grant  out  2  one-hot owner of the bus; 00 = none
- m_start  out  1  one-cycle start pulse to the byte-level I2C master
- m_we, m_dev_addr[6:0], m_reg_addr[7:0], m_wdata[7:0]  out  command fields, stable from m_start until m_done
- m_done  in  1  one-cycle completion pulse from the master
- m_nack  in  1  valid with m_done; 1 = slave did not acknowledge
- m_rdata  in  8  valid with m_done

Function
REQ-005 The block SHALL implement an FSM with the states IDLE, ISSUE, WAIT and GAP.
REQ-006 IDLE: when any req is high, the block SHALL select the owner, set grant, latch that requester's we/addr/wdata into the m_* fields, and go to ISSUE on the next edge.
REQ-007 Arbitration SHALL be round-robin:
- a single request wins outright;
- when req0 and req1 are both high, the requester that was not the last owner wins;
- after reset, the last owner SHALL be requester 1, so requester 0 wins the first tie.
REQ-008 ISSUE: the block SHALL assert m_start for exactly one cycle, clear the timeout counter and go to WAIT.
REQ-009 WAIT, on m_done:
- the block SHALL pulse done of the owner for one cycle on the next edge;
- it SHALL set err to m_nack;
- for a read with m_nack = 0, it SHALL load rdata from m_rdata;
- rdata SHALL be unchanged for writes and for NACKed reads.
REQ-010 WAIT, exit on m_done:
- write with m_nack = 0: go to GAP;
- otherwise: go to IDLE and clear grant.
REQ-011 WAIT timeout: if the timeout counter reaches TIMEOUT_CYC - 1 without m_done, the block SHALL pulse done of the owner, set err = 1, clear grant and go to IDLE; a later m_done SHALL be ignored.
REQ-012 GAP: the block SHALL count WR_GAP_CYC cycles with grant held, ignore all req, and then clear grant and go to IDLE.
REQ-013 Minimum latency SHALL be: req sampled in IDLE at edge N, m_start high after edge N+1, done high the cycle after the edge that samples m_done.
REQ-014 A req held high after done SHALL be treated as a new request; round-robin SHALL guarantee the other pending requester is served next.
REQ-015 A requester's req, we, addr and wdata changing while it is not in IDLE-selection SHALL have no effect on the command in flight.
REQ-016 m_start and m_done in the same cycle are illegal master behaviour; m_done SHALL only be honoured in WAIT.
REQ-017 Counters SHALL be 24 bits wide and SHALL saturate, never wrap.

Reset
REQ-018 On rst_n low, asynchronously:
- state SHALL be IDLE;
- grant, m_start, done0, done1 and err SHALL be 0;
- rdata, m_reg_addr and m_wdata SHALL be 8'h00;
- m_we SHALL be 0;
- m_dev_addr SHALL be DEV_ADDR;
- counters SHALL be 0;
- the last owner SHALL be requester 1.
REQ-019 Reset asserted mid-transaction SHALL abandon it with no done pulse; after release, the first transaction SHALL start from IDLE.

Verification
REQ-020 req0 write addr 8'h05 data 8'hA5, master returns m_nack = 0 after 50 cycles -> single m_start; m_we = 1, m_reg_addr = 05, m_wdata = A5; done0 pulse with err = 0; grant = 01 for 4800 further cycles, then 00.
REQ-021 req1 read addr 8'h05, master returns m_rdata = 8'hA5 -> done1 pulse, rdata = A5, err = 0, no GAP.
REQ-022 req0 and req1 raised in the same cycle right after reset, both held -> requester 0 served first, then requester 1, then requester 0 again (alternating).
REQ-023 Master returns m_nack = 1 on a write -> done pulse with err = 1, no GAP, next request issued within 3 cycles.
REQ-024 m_done never returned, TIMEOUT_CYC = 100 -> done pulse with err = 1 exactly 100 cycles after m_start; a late m_done is ignored.
REQ-025 rst_n pulsed low during WAIT -> all outputs at reset values immediately, no done pulse, and the next req0 is served normally.
